// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the single register-file write port.
//
// Merges ALU results (unbuffered) and memory load returns (buffered in a
// small FIFO, the load queue) into one registered register-file write per
// cycle, with backpressure so neither source drops data.
//
// Ports:
//   clk, Reset               clock and asynchronous active-high reset
//   alu_valid/ready/rd/data  ALU result handshake
//   mem_valid/ready/rd/data  load-return handshake (enqueued into the LQ)
//   nD, D, RegWE             registered register-file write index/data/enable
//   lq_count                 load-queue occupancy
//   nA, nB, nC               register-file read indices (forwarding compare)
//   fwdA, fwdB, fwdC         per-read-port forward hit
//
// Build option: define WB_FWD_EN to enable the forwarding comparators;
// otherwise fwdA/fwdB/fwdC are tied low and nA/nB/nC are ignored.

module wb_arbiter #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [AW-1:0]               alu_rd,
  input  logic [DW-1:0]               alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [AW-1:0]               mem_rd,
  input  logic [DW-1:0]               mem_data,
  output logic [AW-1:0]               nD,
  output logic [DW-1:0]               D,
  output logic                        RegWE,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  input  logic [AW-1:0]               nA,
  input  logic [AW-1:0]               nB,
  input  logic [AW-1:0]               nC,
  output logic                        fwdA,
  output logic                        fwdB,
  output logic                        fwdC
);

  localparam int unsigned PW = $clog2(LQ_DEPTH);
  localparam logic [PW:0] FullLevel = (PW + 1)'(LQ_DEPTH);
  localparam logic [PW:0] NfLevel   = (PW + 1)'(LQ_DEPTH - 1);

  // Load-queue storage (no reset needed: validity is tracked by count_q).
  logic [AW-1:0] lq_rd_q   [LQ_DEPTH];
  logic [DW-1:0] lq_data_q [LQ_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] nd_q, nd_d;
  logic [DW-1:0] d_q, d_d;
  logic          regwe_q, regwe_d;

  logic nf, push, pick_lq, pick_alu;

  assign nf        = (count_q >= NfLevel);
  assign mem_ready = (count_q < FullLevel);
  // Depends on state only, never on alu_valid.
  assign alu_ready = !nf;
  assign push      = mem_valid && mem_ready;

  // Winner selection. nf implies a non-empty queue since LQ_DEPTH >= 2.
  always_comb begin
    pick_lq  = 1'b0;
    pick_alu = 1'b0;
    if (nf) begin
      pick_lq = 1'b1;
    end else if (alu_valid) begin
      pick_alu = 1'b1;
    end else if (count_q != '0) begin
      pick_lq = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pick_lq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pick_lq) begin
      count_d = count_q + (PW + 1)'(1);
    end else if (!push && pick_lq) begin
      count_d = count_q - (PW + 1)'(1);
    end
  end

  // r0 writes still complete the handshake and update nD/D, but never assert RegWE.
  always_comb begin
    nd_d    = nd_q;
    d_d     = d_q;
    regwe_d = 1'b0;
    if (pick_lq) begin
      nd_d    = lq_rd_q[rd_ptr_q];
      d_d     = lq_data_q[rd_ptr_q];
      regwe_d = (lq_rd_q[rd_ptr_q] != '0);
    end else if (pick_alu) begin
      nd_d    = alu_rd;
      d_d     = alu_data;
      regwe_d = (alu_rd != '0);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nd_q     <= '0;
      d_q      <= '0;
      regwe_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nd_q     <= nd_d;
      d_q      <= d_d;
      regwe_q  <= regwe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_q[wr_ptr_q]   <= mem_rd;
      lq_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign nD       = nd_q;
  assign D        = d_q;
  assign RegWE    = regwe_q;
  assign lq_count = count_q;

`ifdef WB_FWD_EN
  // RegWE already implies nD != 0, so r0 reads never forward.
  assign fwdA = regwe_q && (nd_q == nA);
  assign fwdB = regwe_q && (nd_q == nB);
  assign fwdC = regwe_q && (nd_q == nC);
`else
  logic unused_read_idx;
  assign unused_read_idx = ^{nA, nB, nC};
  assign fwdA = 1'b0;
  assign fwdB = 1'b0;
  assign fwdC = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter feeding the single write port of the 16×16-bit register file. It merges results from two producers into one registered write per cycle: the ALU, which is unbuffered, and memory load returns, which are buffered in a small FIFO. It drives the register file's `nD`/`D`/`RegWE` inputs and applies backpressure so that neither source loses data.

## Interface
Parameters:
- `DW`, 16, data width (matches register width)
- `AW`, 4, register index width
- `LQ_DEPTH`, 4, load-queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_rd`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `mem_valid`  in  1  load return present
- `mem_ready`  out  1  load return enqueued this cycle when high with `mem_valid`
- `mem_rd`  in  AW  load destination register
- `mem_data`  in  DW  load data
- `nD`  out  AW  register file write index (registered)
- `D`  out  DW  register file write data (registered)
- `RegWE`  out  1  register file write enable (registered)
- `lq_count`  out  log2(LQ_DEPTH)+1  load-queue occupancy
- `nA`, `nB`, `nC`  in  AW  read indices of the register file ports
- `fwdA`, `fwdB`, `fwdC`  out  1  forward hit per read port (see Configuration)

## Operation
- **Load queue (LQ):**
  - FIFO of {rd, data}, depth `LQ_DEPTH`.
  - `mem_ready = (lq_count < LQ_DEPTH)`.
  - A push occurs on `mem_valid && mem_ready`.
- **Near-full threshold:** `nf = (lq_count >= LQ_DEPTH-1)`.
- **ALU acceptance:** `alu_ready = !nf`. This is combinational from state only and never depends on `alu_valid`.
- **Per-cycle winner selection, in priority order:**
  1. `nf` → LQ head.
  2. `alu_valid` → ALU.
  3. LQ not empty → LQ head.
  4. Otherwise, no write.
- **Pop:** the LQ head is popped when it wins.
- **Push and pop in the same cycle:** `lq_count` is unchanged. When full, no push occurs, so the pop frees one slot for the next cycle.
- **Output registration:** the winner's rd/data are registered into `nD`/`D`. `RegWE` is set to 1 iff a winner exists and its rd ≠ 0.
- **Writes to r0:** the handshake completes (item consumed/popped), `RegWE` = 0, and `nD`/`D` still update.
- **No winner:** `RegWE` = 0, and `nD`/`D` hold their previous values.
- **Ordering:** LQ entries leave strictly in arrival order. No ordering is guaranteed between the ALU and the LQ; the scheduler guarantees that no two in-flight writes target the same register.

## Timing
- **Reset (asynchronous, immediate):**
  - `RegWE`=0, `nD`=0, `D`=0, `lq_count`=0.
  - LQ flushed; pointers return to 0.
  - `mem_ready`=1, `alu_ready`=1.
  - Reset in mid-operation discards queued loads and any pending write. The write registered on the edge coinciding with reset assertion is lost.
- **Latency:**
  - An ALU result accepted at edge N appears on `RegWE`/`nD`/`D` after edge N.
  - A load pushed at edge N has its earliest write at edge N+1, visible after N+1.
- **Throughput:** one register write per cycle, sustained.
- **Pointer wrap:** pointers wrap modulo `LQ_DEPTH`; `lq_count` disambiguates full from empty.
- **Worst-case ALU stall:** while `nf` holds, the LQ drains one entry per cycle, so the ALU stall is bounded by 2 cycles once `mem_valid` drops.

## Configuration
- **`WB_FWD_EN` defined:**
  - `fwdX = RegWE && (nD == nX)` for X ∈ {A,B,C}.
  - `nD` ≠ 0 is implied by `RegWE`.
  - Consumers mux `D` over the register file read when `fwdX`=1, covering the write-then-read cycle.
- **`WB_FWD_EN` undefined:**
  - `fwdA`/`fwdB`/`fwdC` tied to 0.
  - `nA`/`nB`/`nC` ignored.
  - No comparator logic is synthesized.

## Test plan
- **ALU only:**
  - Stimulus: `alu_valid`=1, rd=5, data=0x1234, with LQ empty.
  - Required: `alu_ready`=1; the next cycle shows `RegWE`=1, `nD`=5, `D`=0x1234; the following cycle `RegWE`=0 once valid drops.
- **Load fill and backpressure:**
  - Stimulus: `mem_valid` held with rd=1..6 while `alu_valid` is held high with rd=9.
  - Required:
    - LQ rises to 3.
    - `alu_ready` drops at count 3.
    - The LQ drains r1, r2, … in order.
    - `mem_ready`=0 only while count=4.
    - No load is lost.
- **Simultaneous push and pop at count 2:**
  - Stimulus: `mem_valid` and an LQ win in the same cycle.
  - Required: `lq_count` stays 2 and the write order is preserved.
- **r0 discard:**
  - Stimulus: ALU result with rd=0, data=0xFFFF.
  - Required: handshake completes and `RegWE` stays 0. A load to r0 is popped and `RegWE` stays 0.
- **Mid-operation reset:**
  - Stimulus: assert `Reset` asynchronously with 3 loads queued.
  - Required: `RegWE`/`lq_count` go to 0 immediately, before the next edge; after release, no stale write appears.
- **`WB_FWD_EN` build:**
  - Stimulus: write r7=0xBEEF with `nB`=7, `nA`=3.
  - Required: `fwdB`=1 and `fwdA`=0 during the `RegWE` cycle. In the non-`WB_FWD_EN` build, all `fwd` outputs are 0.
